// File: rtl/ctrl_pkg.sv
// Shared decode constants, state encoding and select encodings for the multicycle controller.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH1, S_FETCH2, S_DECODE, S_ALU_EXEC, S_ALU_WB, S_DONE,
        S_LD_ADDR, S_LD_MEM, S_LD_MDR, S_LD_WB, S_ST_WRITE,
        S_BRANCH, S_JCOND, S_JAL_INC, S_JAL_LINK, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU, CL_CMP, CL_LOAD, CL_STOR, CL_BCOND, CL_JCOND, CL_JAL, CL_ILLEGAL
    } iclass_t;

    typedef struct packed {
        iclass_t cls;
        logic    imm;
    } decode_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1111;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_MEMJ  = 4'b0100;
    localparam logic [3:0] OP_BCOND = 4'b1100;

    localparam logic [3:0] EXT_ADD   = 4'b0101;
    localparam logic [3:0] EXT_SUB   = 4'b1001;
    localparam logic [3:0] EXT_CMP   = 4'b1011;
    localparam logic [3:0] EXT_AND   = 4'b0001;
    localparam logic [3:0] EXT_OR    = 4'b0010;
    localparam logic [3:0] EXT_XOR   = 4'b0011;
    localparam logic [3:0] EXT_MOV   = 4'b1101;
    localparam logic [3:0] EXT_LSH   = 4'b0100;
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JAL   = 4'b1000;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_HI = 4'b0100;
    localparam logic [3:0] CC_LS = 4'b0101;
    localparam logic [3:0] CC_GT = 4'b0110;
    localparam logic [3:0] CC_LE = 4'b0111;
    localparam logic [3:0] CC_FS = 4'b1000;
    localparam logic [3:0] CC_FC = 4'b1001;
    localparam logic [3:0] CC_LO = 4'b1010;
    localparam logic [3:0] CC_HS = 4'b1011;
    localparam logic [3:0] CC_LT = 4'b1100;
    localparam logic [3:0] CC_GE = 4'b1101;
    localparam logic [3:0] CC_UC = 4'b1110;

    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

    localparam logic [1:0] SRC1_PC   = 2'd0;
    localparam logic [1:0] SRC1_A    = 2'd1;
    localparam logic [1:0] SRC1_ZERO = 2'd2;
    localparam logic [1:0] SRC1_ONE  = 2'd3;
    localparam logic [1:0] SRC2_B    = 2'd0;
    localparam logic [1:0] SRC2_IMM  = 2'd1;
    localparam logic [1:0] SRC2_ONE  = 2'd2;
    localparam logic [1:0] SRC2_ZERO = 2'd3;
    localparam logic [1:0] PCSRC_INC  = 2'd0;
    localparam logic [1:0] PCSRC_B    = 2'd1;
    localparam logic [1:0] PCSRC_IMM  = 2'd2;
    localparam logic [1:0] PCSRC_ZERO = 2'd3;

    function automatic decode_t decodeInstr(input logic [15:0] instr);
        decode_t d;
        d.cls = CL_ILLEGAL;
        d.imm = 1'b0;
        case (instr[15:12])
            OP_RTYPE: begin
                case (instr[7:4])
                    EXT_ADD, EXT_SUB, EXT_AND, EXT_OR, EXT_XOR, EXT_MOV: d.cls = CL_ALU;
                    EXT_CMP: d.cls = CL_CMP;
                    default: d.cls = CL_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_MOVI, OP_LUI: begin
                d.cls = CL_ALU;
                d.imm = 1'b1;
            end
            OP_CMPI: begin
                d.cls = CL_CMP;
                d.imm = 1'b1;
            end
            OP_SHIFT: begin
                if (instr[7:4] == EXT_LSH) begin
                    d.cls = CL_ALU;
                end else if (instr[7:5] == 3'b000) begin
                    d.cls = CL_ALU;
                    d.imm = 1'b1;
                end
            end
            OP_MEMJ: begin
                case (instr[7:4])
                    EXT_LOAD:  d.cls = CL_LOAD;
                    EXT_STOR:  d.cls = CL_STOR;
                    EXT_JAL:   d.cls = CL_JAL;
                    EXT_JCOND: d.cls = CL_JCOND;
                    default:   d.cls = CL_ILLEGAL;
                endcase
            end
            OP_BCOND: d.cls = CL_BCOND;
            default:  d.cls = CL_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/controller_if.sv
// Controller <-> datapath bundle: instruction/status in, control strobes and selects out.
interface controller_if;
    logic [15:0] instr;
    logic [7:0]  PSR;
    logic        aluOutIsZero;
    logic        pcEn;
    logic        instrWrite;
    logic        newAluInput;
    logic        regWrite;
    logic        writeBackSelect;
    logic        dataToWriteSelect;
    logic [1:0]  aluSrc1Select;
    logic [1:0]  aluSrc2Select;
    logic [1:0]  pcSrc;
    logic        memWrite;
    logic        iOrD;
    logic        illegalOp;

    modport master (
        input  instr, PSR, aluOutIsZero,
        output pcEn, instrWrite, newAluInput, regWrite, writeBackSelect,
               dataToWriteSelect, aluSrc1Select, aluSrc2Select, pcSrc,
               memWrite, iOrD, illegalOp
    );

    modport slave (
        output instr, PSR, aluOutIsZero,
        input  pcEn, instrWrite, newAluInput, regWrite, writeBackSelect,
               dataToWriteSelect, aluSrc1Select, aluSrc2Select, pcSrc,
               memWrite, iOrD, illegalOp
    );
endinterface

// File: rtl/controller_cond_eval.sv
// Branch/jump condition evaluation: condition field plus PSR flags -> taken.
module cond_eval
    import ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [7:0] psr,
    output logic       taken
);
    logic c, l, f, z, n;
    logic unusedPsr;

    assign c = psr[PSR_C];
    assign l = psr[PSR_L];
    assign f = psr[PSR_F];
    assign z = psr[PSR_Z];
    assign n = psr[PSR_N];
    assign unusedPsr = ^{psr[4:3], psr[1]};

    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_EQ: taken = z;
            CC_NE: taken = !z;
            CC_CS: taken = c;
            CC_CC: taken = !c;
            CC_HI: taken = l;
            CC_LS: taken = !l;
            CC_GT: taken = n;
            CC_LE: taken = !n;
            CC_FS: taken = f;
            CC_FC: taken = !f;
            CC_LO: taken = !l && !z;
            CC_HS: taken = l || z;
            CC_LT: taken = !n && !z;
            CC_GE: taken = n || z;
            CC_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/controller.sv
// Multicycle control FSM for the 16-bit CR16-style datapath.
// Optional CTRL_ILLEGAL_TRAP_EN: undefined encodings trap to PC=0 and set sticky illegalOp.
module controller
    import ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    controller_if.master bus
);
    state_t     state, nextState;
    decode_t    dec;
    logic       immForm, isCmp, taken;
    logic       pcEn, instrWrite, newAluInput, regWrite, writeBackSelect;
    logic       dataToWriteSelect, memWrite, iOrD;
    logic [1:0] aluSrc1Select, aluSrc2Select, pcSrc;
    logic       unusedBits;

    assign dec        = decodeInstr(bus.instr);
    assign unusedBits = ^{bus.aluOutIsZero, bus.instr[3:0]};

    cond_eval uCond (
        .cond  (bus.instr[11:8]),
        .psr   (bus.PSR),
        .taken (taken)
    );

    // Operand form and compare-ness are captured at DECODE so EXEC outputs stay registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH1;
            immForm <= 1'b0;
            isCmp   <= 1'b0;
        end else begin
            state <= nextState;
            if (state == S_DECODE) begin
                immForm <= dec.imm;
                isCmp   <= (dec.cls == CL_CMP);
            end
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegalReg;
    always_ff @(posedge clk) begin
        if (reset)
            illegalReg <= 1'b0;
        else if (state == S_DECODE && dec.cls == CL_ILLEGAL)
            illegalReg <= 1'b1;
    end
    assign bus.illegalOp = illegalReg;
`else
    assign bus.illegalOp = 1'b0;
`endif

    always_comb begin
        nextState         = S_FETCH1;
        pcEn              = 1'b0;
        instrWrite        = 1'b0;
        newAluInput       = 1'b0;
        regWrite          = 1'b0;
        writeBackSelect   = 1'b0;
        dataToWriteSelect = 1'b0;
        aluSrc1Select     = SRC1_PC;
        aluSrc2Select     = SRC2_B;
        pcSrc             = PCSRC_INC;
        memWrite          = 1'b0;
        iOrD              = 1'b0;
        case (state)
            S_FETCH1: nextState = S_FETCH2;
            S_FETCH2: begin
                instrWrite = 1'b1;
                nextState  = S_DECODE;
            end
            S_DECODE: begin
                newAluInput = 1'b1;
                case (dec.cls)
                    CL_ALU, CL_CMP: nextState = S_ALU_EXEC;
                    CL_LOAD:        nextState = S_LD_ADDR;
                    CL_STOR:        nextState = S_ST_WRITE;
                    CL_BCOND:       nextState = S_BRANCH;
                    CL_JCOND:       nextState = S_JCOND;
                    CL_JAL:         nextState = S_JAL_INC;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:        nextState = S_TRAP;
`else
                    default:        nextState = S_DONE;
`endif
                endcase
            end
            S_ALU_EXEC: begin
                aluSrc1Select = SRC1_A;
                aluSrc2Select = immForm ? SRC2_IMM : SRC2_B;
                nextState     = isCmp ? S_DONE : S_ALU_WB;
            end
            S_ALU_WB: begin
                regWrite = 1'b1;
                pcEn     = 1'b1;
            end
            S_DONE: pcEn = 1'b1;
            S_LD_ADDR: begin
                iOrD      = 1'b1;
                nextState = S_LD_MEM;
            end
            S_LD_MEM: begin
                iOrD      = 1'b1;
                nextState = S_LD_MDR;
            end
            S_LD_MDR: begin
                writeBackSelect = 1'b1;
                nextState       = S_LD_WB;
            end
            S_LD_WB: begin
                regWrite = 1'b1;
                pcEn     = 1'b1;
            end
            S_ST_WRITE: begin
                iOrD     = 1'b1;
                memWrite = 1'b1;
                pcEn     = 1'b1;
            end
            S_BRANCH: begin
                pcEn  = 1'b1;
                pcSrc = taken ? PCSRC_IMM : PCSRC_INC;
            end
            S_JCOND: begin
                pcEn  = 1'b1;
                pcSrc = taken ? PCSRC_B : PCSRC_INC;
            end
            S_JAL_INC: begin
                pcEn      = 1'b1;
                nextState = S_JAL_LINK;
            end
            // PC already holds the link address; B was latched at DECODE so the target survives the link write.
            S_JAL_LINK: begin
                regWrite          = 1'b1;
                dataToWriteSelect = 1'b1;
                pcEn              = 1'b1;
                pcSrc             = PCSRC_B;
            end
            S_TRAP: begin
                pcEn  = 1'b1;
                pcSrc = PCSRC_ZERO;
            end
            default: nextState = S_FETCH1;
        endcase
    end

    assign bus.pcEn              = pcEn;
    assign bus.instrWrite        = instrWrite;
    assign bus.newAluInput       = newAluInput;
    assign bus.regWrite          = regWrite;
    assign bus.writeBackSelect   = writeBackSelect;
    assign bus.dataToWriteSelect = dataToWriteSelect;
    assign bus.aluSrc1Select     = aluSrc1Select;
    assign bus.aluSrc2Select     = aluSrc2Select;
    assign bus.pcSrc             = pcSrc;
    assign bus.memWrite          = memWrite;
    assign bus.iOrD              = iOrD;
endmodule
